mpu_entry_writer: RTL and testbench

- Bus initiator that programs one MPU table entry in the memory-resident MPU table, or clears one.
- Issues the entry's five word writes over the pico memory interface (valid/ready/addr/wdata/wstrb) toward the memory-side MPU.
- Always uses the mandated update order, so a partially written entry is never treated as valid.
- Sits beside the CPU as a secondary initiator; it is driven by a boot or config controller through a valid/ready command port.

---
 rtl/mpu_pkg.sv | 40 ++++
 rtl/mpu_entry_addr_gen.sv | 19 +
 rtl/mpu_entry_writer.sv | 157 +++++++++++++++
 tb/tb_mpu_entry_writer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_pkg.sv
// mpu_pkg: word offsets, ACL bit positions, writer states and write-order tables for the MPU table
package mpu_pkg;
    localparam int OFF_CODE_START = 1;
    localparam int OFF_CODE_END   = 2;
    localparam int OFF_DATA_START = 3;
    localparam int OFF_DATA_END   = 4;
    localparam int OFF_ACL        = 5;
    localparam int ACL_R = 2;
    localparam int ACL_W = 1;
    localparam int ACL_X = 0;
    localparam logic [2:0] LAST_K = 3'd4;
    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_LOW,
        ABORT,
        DONE
`ifdef MPU_ENTRY_WRITER_VERIFY_EN
        , RD_REQ
        , RD_WAIT_LOW
`endif
    } state_e;
    typedef enum logic [2:0] {
        F_ZERO       = 3'd0,
        F_CODE_START = 3'd1,
        F_CODE_END   = 3'd2,
        F_DATA_START = 3'd3,
        F_DATA_END   = 3'd4,
        F_ACL        = 3'd5
    } field_e;
    // k=0 sits in the low 3 bits; programming writes code_end last so the entry only
    // becomes valid once complete, clearing writes code_end first so it is invalid at once
    localparam logic [14:0] PROG_ORDER = {3'(OFF_CODE_END), 3'(OFF_CODE_START), 3'(OFF_DATA_END),
                                          3'(OFF_DATA_START), 3'(OFF_ACL)};
    localparam logic [14:0] CLR_ORDER  = {3'(OFF_ACL), 3'(OFF_DATA_END), 3'(OFF_DATA_START),
                                          3'(OFF_CODE_START), 3'(OFF_CODE_END)};
    function automatic logic [2:0] order_off(input logic clear, input logic [2:0] k);
        return clear ? CLR_ORDER[3*k +: 3] : PROG_ORDER[3*k +: 3];
    endfunction
endpackage

// File: rtl/mpu_entry_addr_gen.sv
// mpu_entry_addr_gen: maps (entry index, beat k, clear) to word offset, data select and table word index
module mpu_entry_addr_gen import mpu_pkg::*; #(
    parameter int MPU_START_ADDR = 768,
    parameter int MPU_ITEM_LEN   = 5
) (
    input  logic [3:0]  index,
    input  logic [2:0]  k,
    input  logic        clear,
    output logic [2:0]  off,
    output field_e      sel,
    output logic [31:0] word_idx
);
    // beat order lookup; clearing always writes zero regardless of the field
    always_comb begin
        off      = order_off(clear, k);
        sel      = clear ? F_ZERO : field_e'(off);
        word_idx = 32'(MPU_START_ADDR) + 32'(index) * 32'(MPU_ITEM_LEN) + 32'(off);
    end
endmodule

// File: rtl/mpu_entry_writer.sv
// mpu_entry_writer: programs or clears one MPU table entry over the pico bus (optional readback: MPU_ENTRY_WRITER_VERIFY_EN)
module mpu_entry_writer import mpu_pkg::*; #(
    parameter int MPU_START_ADDR = 768,
    parameter int MPU_ITEM_NUM   = 16,
    parameter int MPU_ITEM_LEN   = 5,
    parameter int ADDR_WIDTH     = 22
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_clear,
    input  logic [3:0]            cmd_index,
    input  logic [31:0]           cmd_code_start,
    input  logic [31:0]           cmd_code_end,
    input  logic [31:0]           cmd_data_start,
    input  logic [31:0]           cmd_data_end,
    input  logic [2:0]            cmd_acl,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic [31:0]           mem_rdata,
    input  logic                  mpu_irq,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam logic [31:0] ITEM_NUM = 32'(MPU_ITEM_NUM);
`ifdef MPU_ENTRY_WRITER_VERIFY_EN
    localparam state_e AFTER_WRITES = RD_REQ;
`else
    localparam state_e AFTER_WRITES = DONE;
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
`endif
    state_e      state, state_nx;
    logic        clr_q;
    logic [3:0]  idx_q;
    logic [31:0] cs_q, ce_q, ds_q, de_q;
    logic [2:0]  acl_q;
    logic [2:0]  k, k_nx;
    logic        err_nx;
    logic [2:0]  off;
    field_e      sel;
    logic [31:0] word_idx, idx32, fdata, acl_word;
    logic        accept, illegal;
    assign idx32     = 32'(cmd_index);
    assign illegal   = idx32 >= ITEM_NUM;
    assign cmd_ready = state == IDLE;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = state != IDLE && state != DONE;
    assign done      = state == DONE;
    mpu_entry_addr_gen #(
        .MPU_START_ADDR(MPU_START_ADDR),
        .MPU_ITEM_LEN  (MPU_ITEM_LEN)
    ) u_addr_gen (
        .index   (idx_q),
        .k       (k),
        .clear   (clr_q),
        .off     (off),
        .sel     (sel),
        .word_idx(word_idx)
    );
    // field value for the current beat: written during programming, expected on readback
    always_comb begin
        acl_word        = '0;
        acl_word[ACL_R] = acl_q[2];
        acl_word[ACL_W] = acl_q[1];
        acl_word[ACL_X] = acl_q[0];
        fdata = sel == F_CODE_START ? cs_q :
                sel == F_CODE_END   ? ce_q :
                sel == F_DATA_START ? ds_q :
                sel == F_DATA_END   ? de_q :
                sel == F_ACL        ? acl_word : '0;
    end
    // state, beat counter, sticky error and command latch
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            k     <= '0;
            err   <= 1'b0;
            clr_q <= 1'b0;
            idx_q <= '0;
            cs_q  <= '0;
            ce_q  <= '0;
            ds_q  <= '0;
            de_q  <= '0;
            acl_q <= '0;
        end else begin
            state <= state_nx;
            k     <= k_nx;
            err   <= err_nx;
            if (accept) begin
                clr_q <= cmd_clear;
                idx_q <= cmd_index;
                cs_q  <= cmd_code_start;
                ce_q  <= cmd_code_end;
                ds_q  <= cmd_data_start;
                de_q  <= cmd_data_end;
                acl_q <= cmd_acl;
            end
        end
    end
    // handshake sequencing; WAIT_LOW keeps a stretched ready from acking the next beat
    always_comb begin
        state_nx  = state;
        k_nx      = k;
        err_nx    = err;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        case (state)
            IDLE: if (cmd_valid) begin
                err_nx   = illegal;
                k_nx     = '0;
                state_nx = illegal ? DONE : REQ;
            end
            REQ: begin
                mem_valid = 1'b1;
                mem_addr  = ADDR_WIDTH'(word_idx << 2);
                mem_wdata = fdata;
                mem_wstrb = 4'hF;
                if (mpu_irq) begin
                    err_nx   = 1'b1;
                    state_nx = ABORT;
                end else if (mem_ready) state_nx = WAIT_LOW;
            end
            WAIT_LOW: if (!mem_ready) begin
                state_nx = k == LAST_K ? AFTER_WRITES : REQ;
                k_nx     = k == LAST_K ? 3'd0 : k + 3'd1;
            end
            ABORT: state_nx = (!mem_ready && !mpu_irq) ? DONE : ABORT;
            DONE: state_nx = IDLE;
`ifdef MPU_ENTRY_WRITER_VERIFY_EN
            RD_REQ: begin
                mem_valid = 1'b1;
                mem_addr  = ADDR_WIDTH'(word_idx << 2);
                if (mpu_irq) begin
                    err_nx   = 1'b1;
                    state_nx = ABORT;
                end else if (mem_ready) begin
                    err_nx   = err || (mem_rdata != fdata);
                    state_nx = RD_WAIT_LOW;
                end
            end
            RD_WAIT_LOW: if (!mem_ready) begin
                state_nx = k == LAST_K ? DONE : RD_REQ;
                k_nx     = k == LAST_K ? 3'd0 : k + 3'd1;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mpu_entry_writer.sv
// tb_mpu_entry_writer: scoreboard bench for mpu_entry_writer; define MPU_ENTRY_WRITER_VERIFY_EN to cover readback
module tb_mpu_entry_writer;
    localparam int ITEM_NUM = 12;
`ifdef MPU_ENTRY_WRITER_VERIFY_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif
    typedef struct packed {
        logic [21:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } beat_t;
    typedef struct {
        int   lat;
        int   beats;
        int   acks;
        int   dones;
        int   rdy_busy;
        logic err;
        logic rdy_done;
        logic rdy_next;
    } res_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_clear = 1'b0;
    logic [3:0]  cmd_index = '0;
    logic [31:0] cmd_code_start = '0, cmd_code_end = '0, cmd_data_start = '0, cmd_data_end = '0;
    logic [2:0]  cmd_acl = '0;
    logic        mem_valid, mem_ready, mpu_irq, busy, done, err;
    logic [21:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int          errors = 0, checks = 0;
    int          hold = 1, irq_at = 0, rcnt = 0, icnt = 0, trig_cnt = 0, ack_cnt = 0;
    logic [21:0] bad_addr = '0;
    logic [31:0] mdl [0:1023];
    beat_t       sbq [$];

    mpu_entry_writer #(.MPU_ITEM_NUM(ITEM_NUM)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_clear(cmd_clear), .cmd_index(cmd_index),
        .cmd_code_start(cmd_code_start), .cmd_code_end(cmd_code_end),
        .cmd_data_start(cmd_data_start), .cmd_data_end(cmd_data_end), .cmd_acl(cmd_acl),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mpu_irq(mpu_irq),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    assign mem_ready = rcnt != 0;
    assign mpu_irq   = icnt != 0;
    assign mem_rdata = mdl[mem_addr[11:2]] ^ ((mem_addr == bad_addr) ? 32'h0000_0100 : 32'h0);

    // responder: one trigger per beat, then either `hold` ready cycles or a 2-cycle fault
    always @(posedge clk) begin
        if (rcnt != 0) rcnt <= rcnt - 1;
        else if (icnt != 0) icnt <= icnt - 1;
        else if (mem_valid) begin
            trig_cnt <= trig_cnt + 1;
            if (irq_at == trig_cnt + 1) icnt <= 2;
            else rcnt <= hold;
        end
    end

    // scoreboard: every acknowledged beat must match the next expected beat
    always @(negedge clk) begin
        beat_t e;
        if (mem_valid && mem_ready && !mpu_irq) begin
            ack_cnt++;
            if (mem_wstrb == 4'hF) mdl[mem_addr[11:2]] = mem_wdata;
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL beat: unexpected a=%h d=%h s=%h", mem_addr, mem_wdata, mem_wstrb);
            end else begin
                e = sbq.pop_front();
                if ({mem_addr, mem_wdata, mem_wstrb} !== {e.a, e.d, e.s}) begin
                    errors++;
                    $display("FAIL beat: got a=%h d=%h s=%h want a=%h d=%h s=%h",
                             mem_addr, mem_wdata, mem_wstrb, e.a, e.d, e.s);
                end
            end
        end
    end

    task automatic push_cmd(input logic clr, input logic [3:0] idx, input logic [31:0] cs,
                            input logic [31:0] ce, input logic [31:0] ds, input logic [31:0] de,
                            input logic [2:0] acl);
        int    offs [5];
        int    o;
        beat_t b;
        if (clr) offs = '{2, 1, 3, 4, 5};
        else offs = '{5, 3, 4, 1, 2};
        for (int p = 0; p < PASSES; p++)
            for (int j = 0; j < 5; j++) begin
                o   = offs[j];
                b.a = 22'(4 * (768 + int'(idx) * 5 + o));
                b.d = (clr || p == 1) ? 32'h0 : o == 1 ? cs : o == 2 ? ce : o == 3 ? ds : o == 4 ? de : {29'b0, acl};
                b.s = p == 1 ? 4'h0 : 4'hF;
                sbq.push_back(b);
            end
    endtask

    task automatic run_cmd(input logic clr, input logic [3:0] idx, input logic [31:0] cs,
                           input logic [31:0] ce, input logic [31:0] ds, input logic [31:0] de,
                           input logic [2:0] acl, input int hc, input int ib, input bit poke,
                           output res_t r);
        int t0, a0;
        @(negedge clk);
        if (int'(idx) < ITEM_NUM) push_cmd(clr, idx, cs, ce, ds, de, acl);
        hold = hc;
        irq_at = ib != 0 ? trig_cnt + ib : 0;
        cmd_clear = clr; cmd_index = idx; cmd_acl = acl;
        cmd_code_start = cs; cmd_code_end = ce; cmd_data_start = ds; cmd_data_end = de;
        cmd_valid = 1'b1;
        t0 = trig_cnt; a0 = ack_cnt;
        r = '{lat: -1, beats: 0, acks: 0, dones: 0, rdy_busy: 0, err: 1'bx, rdy_done: 1'bx, rdy_next: 1'bx};
        @(posedge clk);
        #1;
        if (poke) begin
            cmd_index = 4'd7; cmd_clear = ~clr; cmd_code_start = 32'hDEAD_BEEF;
        end else cmd_valid = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (busy && cmd_ready) r.rdy_busy++;
            if (r.lat >= 0 && n == r.lat + 1) r.rdy_next = cmd_ready;
            if (done) begin
                r.dones++;
                if (r.lat < 0) begin
                    r.lat = n; r.err = err; r.rdy_done = cmd_ready; cmd_valid = 1'b0;
                end
            end
            if (r.lat >= 0 && n >= r.lat + 3) break;
        end
        cmd_valid = 1'b0;
        r.beats = trig_cnt - t0;
        r.acks  = ack_cnt - a0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_valid, mem_addr, mem_wdata, mem_wstrb, busy, done, err, cmd_ready} !== {63'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got v=%b a=%h d=%h s=%h busy=%b done=%b err=%b rdy=%b want zeros, rdy=1",
                     mem_valid, mem_addr, mem_wdata, mem_wstrb, busy, done, err, cmd_ready);
        end
        reset = 1'b0;
    endtask

    task automatic test_program;
        res_t r;
        run_cmd(1'b0, 4'd2, 32'h100, 32'h1FF, 32'h300, 32'h33F, 3'b110, 1, 0, 1'b0, r);
        checks++; if (r.lat !== 15 * PASSES + 1) begin errors++; $display("FAIL program_latency: got %0d want %0d", r.lat, 15 * PASSES + 1); end
        checks++; if (r.beats !== 5 * PASSES) begin errors++; $display("FAIL program_beats: got %0d want %0d", r.beats, 5 * PASSES); end
        checks++; if (r.err !== 1'b0) begin errors++; $display("FAIL program_err: got %b want 0", r.err); end
        checks++; if (r.dones !== 1) begin errors++; $display("FAIL program_done_count: got %0d want 1", r.dones); end
        checks++; if ({r.rdy_done, r.rdy_next} !== 2'b01) begin errors++; $display("FAIL program_ready_after_done: got %b%b want 01", r.rdy_done, r.rdy_next); end
        checks++; if (sbq.size() !== 0) begin errors++; $display("FAIL program_left: got %0d want 0", sbq.size()); end
        sbq.delete();
    endtask

    task automatic test_stretched;
        res_t r;
        run_cmd(1'b0, 4'd2, 32'h100, 32'h1FF, 32'h300, 32'h33F, 3'b110, 3, 0, 1'b1, r);
        checks++; if (r.lat !== 25 * PASSES + 1) begin errors++; $display("FAIL stretch_latency: got %0d want %0d", r.lat, 25 * PASSES + 1); end
        checks++; if (r.beats !== 5 * PASSES || r.acks !== 5 * PASSES) begin errors++; $display("FAIL stretch_beats: got %0d/%0d want %0d", r.beats, r.acks, 5 * PASSES); end
        checks++; if (r.rdy_busy !== 0) begin errors++; $display("FAIL stretch_ready_busy: got %0d want 0", r.rdy_busy); end
        checks++; if (sbq.size() !== 0) begin errors++; $display("FAIL stretch_left: got %0d want 0", sbq.size()); end
        sbq.delete();
    endtask

    task automatic test_clear;
        res_t r;
        run_cmd(1'b1, 4'd0, 32'h1, 32'h2, 32'h3, 32'h4, 3'b111, 1, 0, 1'b0, r);
        checks++; if (r.err !== 1'b0) begin errors++; $display("FAIL clear_err: got %b want 0", r.err); end
        checks++; if (r.acks !== 5 * PASSES) begin errors++; $display("FAIL clear_beats: got %0d want %0d", r.acks, 5 * PASSES); end
        sbq.delete();
    endtask

    task automatic test_illegal;
        res_t r;
        int   bad [2] = '{12, 15};
        for (int i = 0; i < 2; i++) begin
            run_cmd(1'b0, 4'(bad[i]), 32'h10, 32'h20, 32'h30, 32'h40, 3'b101, 1, 0, 1'b0, r);
            checks++; if (r.lat !== 1) begin errors++; $display("FAIL illegal_latency idx=%0d: got %0d want 1", bad[i], r.lat); end
            checks++; if (r.beats !== 0) begin errors++; $display("FAIL illegal_beats idx=%0d: got %0d want 0", bad[i], r.beats); end
            checks++; if (r.err !== 1'b1 || r.dones !== 1) begin errors++; $display("FAIL illegal_err idx=%0d: got err=%b dones=%0d want 1/1", bad[i], r.err, r.dones); end
        end
    endtask

    task automatic test_boundary;
        res_t r;
        run_cmd(1'b0, 4'd11, $urandom, $urandom, $urandom, $urandom, 3'($urandom_range(0, 7)), 1, 0, 1'b0, r);
        checks++; if (r.err !== 1'b0 || r.acks !== 5 * PASSES) begin errors++; $display("FAIL last_entry: got err=%b acks=%0d want 0/%0d", r.err, r.acks, 5 * PASSES); end
        checks++; if (sbq.size() !== 0) begin errors++; $display("FAIL last_entry_left: got %0d want 0", sbq.size()); end
        sbq.delete();
    endtask

    task automatic test_irq;
        res_t r;
        run_cmd(1'b0, 4'd3, 32'h400, 32'h4FF, 32'h500, 32'h5FF, 3'b100, 1, 3, 1'b0, r);
        irq_at = 0;
        checks++; if (r.beats !== 3 || r.acks !== 2) begin errors++; $display("FAIL irq_beats: got %0d/%0d want 3/2", r.beats, r.acks); end
        checks++; if (r.err !== 1'b1 || r.dones !== 1) begin errors++; $display("FAIL irq_err: got err=%b dones=%0d want 1/1", r.err, r.dones); end
        checks++; if (sbq.size() !== 5 * PASSES - 2) begin errors++; $display("FAIL irq_left: got %0d want %0d", sbq.size(), 5 * PASSES - 2); end
        sbq.delete();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL irq_sticky: got %b want 1", err); end
        run_cmd(1'b1, 4'd3, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 1, 0, 1'b0, r);
        checks++; if (r.err !== 1'b0 || r.acks !== 5 * PASSES) begin errors++; $display("FAIL irq_recover: got err=%b acks=%0d want 0/%0d", r.err, r.acks, 5 * PASSES); end
        sbq.delete();
    endtask

    task automatic test_reset_mid;
        int a0, quiet;
        bit found;
        @(negedge clk);
        push_cmd(1'b0, 4'd5, 32'h600, 32'h6FF, 32'h700, 32'h7FF, 3'b011);
        hold = 1; irq_at = 0;
        cmd_clear = 1'b0; cmd_index = 4'd5; cmd_acl = 3'b011;
        cmd_code_start = 32'h600; cmd_code_end = 32'h6FF; cmd_data_start = 32'h700; cmd_data_end = 32'h7FF;
        cmd_valid = 1'b1;
        a0 = ack_cnt; found = 1'b0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (mem_valid && ack_cnt - a0 == 1) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL reset_mid_reach_beat2: got timeout want beat 2"); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({mem_valid, busy, cmd_ready} !== 3'b001) begin errors++; $display("FAIL reset_mid_state: got v=%b busy=%b rdy=%b want 0/0/1", mem_valid, busy, cmd_ready); end
        reset = 1'b0;
        quiet = 0;
        repeat (6) begin
            @(negedge clk);
            if (mem_valid) quiet++;
        end
        checks++; if (quiet !== 0) begin errors++; $display("FAIL reset_mid_bus_quiet: got %0d valid cycles want 0", quiet); end
        sbq.delete();
    endtask

`ifdef MPU_ENTRY_WRITER_VERIFY_EN
    task automatic test_verify;
        res_t r;
        bad_addr = 22'(4 * (768 + 4 * 5 + 4));
        run_cmd(1'b0, 4'd4, 32'h800, 32'h8FF, 32'h900, 32'h9FF, 3'b111, 1, 0, 1'b0, r);
        bad_addr = '0;
        checks++; if (r.err !== 1'b1) begin errors++; $display("FAIL verify_err: got %b want 1", r.err); end
        checks++; if (r.beats !== 10 || r.acks !== 10) begin errors++; $display("FAIL verify_beats: got %0d/%0d want 10", r.beats, r.acks); end
        sbq.delete();
    endtask
`endif

    initial begin
        test_reset;
        test_program;
        test_stretched;
        test_clear;
        test_illegal;
        test_boundary;
        test_irq;
        test_reset_mid;
`ifdef MPU_ENTRY_WRITER_VERIFY_EN
        test_verify;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test want finish");
        $fatal(1);
    end
endmodule
